// File: rtl/sfq_if_pkg.sv
// Shared definitions for the SFQ output deserializer.
//   win_state_e     : slot-window state (IDLE = not armed, OPEN = armed)
//   DEF_WIDTH       : default number of slots packed per output word
//   DEF_SYNC_STAGES : default synchronizer depth on each toggle input
//   PULSE_CNT_W     : width of the optional data-pulse counter
package sfq_if_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } win_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int PULSE_CNT_W     = 16;

endpackage

// File: rtl/sfq_out_deser_if.sv
// Output word channel of the SFQ deserializer (valid/ready handshake).
//   out_data  : packed word, slot n at bit n
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts the word when out_valid is also high
// Modports: master (deserializer side), slave (consumer side).
interface sfq_out_deser_if
  import sfq_if_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sfq_toggle_det.sv
// Toggle-input front end: SYNC_STAGES-deep synchronizer followed by an edge
// detector that turns every level change into a one-cycle pulse.
//   clk, rst : clock, asynchronous active-high reset
//   tgl      : toggle-encoded asynchronous input
//   pulse    : one-cycle pulse per synchronized level change
// After reset release the detector stays quiet until the synchronizer holds
// a real input sample and the history has loaded it, so an input that is
// already high at release never produces a pulse.
module sfq_toggle_det
  import sfq_if_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse
);

  // Prime period: SYNC_STAGES cycles to fill the chain with live samples,
  // plus the cycle in which the history loads the synchronized level.
  localparam int PRIME_CYC = SYNC_STAGES + 1;
  localparam int PCW       = $clog2(PRIME_CYC + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic [PCW-1:0]         prime_cnt;
  logic                   primed;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      hist      <= 1'b0;
      prime_cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tgl};
      hist <= sync[SYNC_STAGES-1];
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign primed = (prime_cnt == PCW'(PRIME_CYC));
  assign pulse  = primed & (sync[SYNC_STAGES-1] ^ hist);

endmodule

// File: rtl/sfq_out_deser.sv
// SFQ output deserializer: packs toggle-encoded data pulses, one bit per
// slot window delimited by a toggle-encoded slot clock, into WIDTH-bit words
// delivered on a valid/ready channel.
//   clk, rst  : clock, asynchronous active-high reset
//   din_t     : toggle-encoded data pulses from the upstream gate output
//   slot_t    : toggle-encoded copy of the upstream gate clock
//   out_bus   : master side of sfq_out_deser_if (out_data/out_valid/out_ready)
//   ovf       : sticky, a completed word was dropped
//   dbl       : sticky, more than one data pulse landed in one window
//   clr_err   : synchronous clear of ovf/dbl (a same-cycle set wins)
//   pulse_cnt : 16-bit count of data pulses, only with the build macro
//               SFQ_OUT_DESER_PULSE_CNT_EN defined
module sfq_out_deser
  import sfq_if_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_t,
  input  logic                    slot_t,
  sfq_out_deser_if.master         out_bus,
  output logic                    ovf,
  output logic                    dbl,
  input  logic                    clr_err
`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
  ,
  output logic [PULSE_CNT_W-1:0]  pulse_cnt
`endif
);

  localparam int CW = $clog2(WIDTH);

  logic             d_p;
  logic             s_p;
  win_state_e       state;
  logic             pending;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_next;
  logic [WIDTH-1:0] word_q;
  logic             xfer;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             slot_bit;
  logic             last_slot;
  logic             dbl_set;
  logic             ovf_set;
  logic             handshake;

  sfq_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_din_det (
    .clk   (clk),
    .rst   (rst),
    .tgl   (din_t),
    .pulse (d_p)
  );

  sfq_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_slot_det (
    .clk   (clk),
    .rst   (rst),
    .tgl   (slot_t),
    .pulse (s_p)
  );

  // A data pulse coincident with the slot pulse belongs to the closing
  // window: the upstream gate emits its output after its clock.
  assign slot_bit  = pending | d_p;
  assign last_slot = (count == CW'(WIDTH - 1));
  assign dbl_set   = (state == OPEN) & d_p & pending;

  // NOTE: every always_comb output gets a full default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    asm_next        = asm_q;
    asm_next[count] = slot_bit;
  end

  // Window tracking and word assembly. Completed words are staged in word_q
  // so assembly of the next word continues without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      count   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      xfer    <= 1'b0;
    end else begin
      xfer <= 1'b0;
      case (state)
        IDLE: begin
          // Data pulses before the first slot boundary have no window.
          if (s_p) begin
            state   <= OPEN;
            pending <= 1'b0;
            count   <= '0;
          end
        end
        OPEN: begin
          if (s_p) begin
            asm_q   <= asm_next;
            pending <= 1'b0;
            if (last_slot) begin
              count  <= '0;
              word_q <= asm_next;
              xfer   <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (d_p) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: a staged word loads when the slot is free or being
  // consumed in the same cycle; otherwise it is dropped and flagged.
  assign handshake = valid_q & out_bus.out_ready;
  assign ovf_set   = xfer & valid_q & ~out_bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf     <= 1'b0;
      dbl     <= 1'b0;
    end else begin
      if (xfer && !ovf_set) begin
        data_q  <= word_q;
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
      ovf <= (ovf & ~clr_err) | ovf_set;
      dbl <= (dbl & ~clr_err) | dbl_set;
    end
  end

  assign out_bus.out_data  = data_q;
  assign out_bus.out_valid = valid_q;

`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
  // Counts every data pulse, armed window or not; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_cnt <= '0;
    else     pulse_cnt <= (clr_err ? '0 : pulse_cnt) + PULSE_CNT_W'(d_p);
  end
`else
  // Counter absent: d_p only feeds the window logic.
`endif

endmodule

// File: tb/tb_sfq_out_deser.sv
module tb_sfq_out_deser;
  import sfq_if_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_t = 1'b0;
  logic slot_t = 1'b0;
  logic clr_err = 1'b0;
  logic ovf, dbl;
`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
  logic [PULSE_CNT_W-1:0] pulse_cnt;
`endif

  sfq_out_deser_if #(.WIDTH(W)) bus ();

  sfq_out_deser #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_t     (din_t),
    .slot_t    (slot_t),
    .out_bus   (bus),
    .ovf       (ovf),
    .dbl       (dbl),
    .clr_err   (clr_err)
`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
    ,
    .pulse_cnt (pulse_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input levels sampled at each clock edge since reset release; a level
  // change becomes visible as a pulse S+1 edges later, and nothing is seen
  // until the first S+2 edges have passed (chain fill plus history load).
  logic         din_smp [0:S+1];
  logic         slot_smp[0:S+1];
  int           n_edges = 0;
  bit           m_open = 0, m_pend = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_word = '0;
  bit           m_xfer = 0;
  logic [W-1:0] m_xword = '0;
  logic [W-1:0] m_od = '0;
  bit           m_ov = 0, m_ovf = 0, m_dbl = 0;
  int           m_pc = 0;

  initial begin
    for (int i = 0; i <= S + 1; i++) begin din_smp[i] = 1'b0; slot_smp[i] = 1'b0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n_edges = 0;
        for (int i = 0; i <= S + 1; i++) begin din_smp[i] = 1'b0; slot_smp[i] = 1'b0; end
        m_open = 0; m_pend = 0; m_cnt = 0; m_word = '0;
        m_xfer = 0; m_xword = '0; m_od = '0; m_ov = 0; m_ovf = 0; m_dbl = 0; m_pc = 0;
      end else begin
        bit dp, sp, new_word, dbl_set, ovf_set, b;
        logic [W-1:0] new_val;
        n_edges++;
        dp = (n_edges >= S + 2) && (din_smp[S-1]  != din_smp[S]);
        sp = (n_edges >= S + 2) && (slot_smp[S-1] != slot_smp[S]);
        for (int i = S + 1; i > 0; i--) begin din_smp[i] = din_smp[i-1]; slot_smp[i] = slot_smp[i-1]; end
        din_smp[0] = din_t; slot_smp[0] = slot_t;

        new_word = 0; new_val = '0; dbl_set = 0; ovf_set = 0;
        if (!m_open) begin
          if (sp) begin m_open = 1; m_pend = 0; m_cnt = 0; m_word = '0; end
        end else begin
          if (dp && m_pend) dbl_set = 1;
          if (sp) begin
            b = m_pend || dp;
            m_word = m_word | (W'(b) << m_cnt);
            m_cnt++;
            m_pend = 0;
            if (m_cnt == W) begin new_word = 1; new_val = m_word; m_cnt = 0; m_word = '0; end
          end else if (dp) m_pend = 1;
        end

        if (m_xfer) begin
          if (!m_ov || bus.out_ready) begin m_od = m_xword; m_ov = 1; end
          else ovf_set = 1;
        end else if (m_ov && bus.out_ready) m_ov = 0;
        m_xfer = new_word; m_xword = new_val;

        if (clr_err) begin m_ovf = 0; m_dbl = 0; m_pc = 0; end
        if (ovf_set) m_ovf = 1;
        if (dbl_set) m_dbl = 1;
        if (dp) m_pc = (m_pc + 1) % 65536;
      end
    end
  end

  // ---------------- compare process + output monitors ----------------
  int           vhi = 0;
  int           acc_n = 0;
  logic [W-1:0] acc_data = '0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("model out_valid", bus.out_valid, m_ov);
      check("model out_data", bus.out_data, m_od);
      check("model ovf", ovf, m_ovf);
      check("model dbl", dbl, m_dbl);
`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
      check("model pulse_cnt", pulse_cnt, m_pc);
`endif
      if (bus.out_valid) vhi++;
      if (bus.out_valid && bus.out_ready) begin acc_n++; acc_data = bus.out_data; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_slot(input bit data);
    if (data) din_t = ~din_t;
    tick(3);
    slot_t = ~slot_t;
    tick(3);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) do_slot(w[i]);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vhi0, acc0;
    bus.out_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 4'h0);
    check("reset ovf", ovf, 1'b0);
    check("reset dbl", dbl, 1'b0);
    tick(5);

    // Arm the window, then pack 1,0,1,1.
    slot_t = ~slot_t;
    tick(4);
    vhi0 = vhi; acc0 = acc_n;
    send_word(4'b1101);
    tick(5);
    check("word 1101 data", acc_data, 4'b1101);
    check("word 1101 valid cycles", vhi - vhi0, 1);
    check("word 1101 accepted", acc_n - acc0, 1);

    // Data pulse coincident with the slot pulse on slot 0.
    din_t = ~din_t; slot_t = ~slot_t;
    tick(3);
    do_slot(0); do_slot(0); do_slot(0);
    tick(5);
    check("simultaneous d_p/s_p word", acc_data, 4'b0001);

    // Two data pulses in one window.
    din_t = ~din_t; tick(3);
    din_t = ~din_t; tick(3);
    slot_t = ~slot_t; tick(3);
    @(negedge clk);
    check("double pulse dbl", dbl, 1'b1);
    do_slot(0); do_slot(0); do_slot(0);
    tick(5);
    check("double pulse word", acc_data, 4'b0001);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    @(negedge clk);
    check("dbl cleared", dbl, 1'b0);

    // Overflow: consumer stalled for two full words.
    bus.out_ready = 1'b0;
    send_word(4'b1111);
    send_word(4'b1111);
    tick(5);
    @(negedge clk);
    check("ovf held data", bus.out_data, 4'hF);
    check("ovf valid held", bus.out_valid, 1'b1);
    check("ovf flag", ovf, 1'b1);
    tick(1);
    bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;
    @(negedge clk);
    check("valid cleared by handshake", bus.out_valid, 1'b0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    @(negedge clk);
    check("ovf cleared", ovf, 1'b0);

    // Handshake in the very cycle a new word transfers: no overflow.
    send_word(4'b0001);
    do_slot(0); do_slot(1); do_slot(0);
    slot_t = ~slot_t;
    tick(3);
    bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;
    @(negedge clk);
    check("same-cycle load data", bus.out_data, 4'b0010);
    check("same-cycle load valid", bus.out_valid, 1'b1);
    check("same-cycle load ovf", ovf, 1'b0);
    bus.out_ready = 1'b1;
    tick(2);

    // Reset mid-word with both toggle inputs high across release.
    do_slot(1); do_slot(1);
    rst = 1'b1;
    din_t = 1'b1; slot_t = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    @(negedge clk);
    check("post-reset valid", bus.out_valid, 1'b0);
    check("post-reset data", bus.out_data, 4'h0);
    check("post-reset dbl", dbl, 1'b0);
    acc0 = acc_n;
    slot_t = ~slot_t;
    tick(4);
    send_word(4'b0110);
    tick(5);
    check("post-reset word", acc_data, 4'b0110);
    check("post-reset word count", acc_n - acc0, 1);

`ifdef SFQ_OUT_DESER_PULSE_CNT_EN
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    @(negedge clk);
    check("pulse_cnt cleared", pulse_cnt, 16'd0);
    for (int i = 0; i < 65537; i++) begin din_t = ~din_t; tick(1); end
    tick(5);
    @(negedge clk);
    check("pulse_cnt wrap", pulse_cnt, 16'd1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sfq_out_deser.md
SFQ_OUT_DESER -- requirements
Module: sfq_out_deser

Interface
REQ-001 Parameter WIDTH, default 8: number of bit slots packed per output word (2..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on each toggle input (2..4).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din_t  input  1  toggle-encoded SFQ data pulse from the upstream clocked gate's out; each transition is one pulse.
REQ-006 slot_t  input  1  toggle-encoded copy of the upstream gate clock; each transition is one slot boundary.
REQ-007 out_data  output  WIDTH  packed word; slot n of the word is at bit n, so the first slot is the LSB.
REQ-008 out_valid  output  1  out_data holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-010 ovf  output  1  sticky flag: a completed word was dropped.
REQ-011 dbl  output  1  sticky flag: more than one data pulse arrived in a single slot window.
REQ-012 clr_err  input  1  synchronous clear of ovf and dbl.

Function
REQ-013 Each toggle input SHALL pass through SYNC_STAGES flops and then an edge detector; any level change of the synchronized value SHALL produce a one-cycle internal pulse (d_p, s_p).
REQ-014 In the first cycle after reset release (prime cycle), the edge-detect history SHALL load the synchronized levels and SHALL generate no pulses.
REQ-015 Window state SHALL be: IDLE, which is not armed after reset, and OPEN, which is armed.
REQ-016 IDLE: the first s_p SHALL move the state to OPEN, clear the pending state and commit no bit; d_p in IDLE SHALL be ignored.
REQ-017 OPEN: d_p SHALL set pending. A d_p while pending is already set SHALL set dbl.
REQ-018 OPEN: on s_p, bit = pending OR d_p in the same cycle; the bit SHALL be shifted into the assembly register at position count, count SHALL increment, and pending SHALL clear.
REQ-019 Simultaneous d_p and s_p SHALL credit the data pulse to the window being closed. This matches upstream gate latency: the output pulse follows the clock pulse.
REQ-020 When count reaches WIDTH, the assembled word SHALL transfer to out_data with out_valid=1 one cycle later, count SHALL wrap to 0, and assembly SHALL continue without a gap.
REQ-021 If out_valid=1 and no handshake occurs in the transfer cycle, the new word SHALL be dropped, ovf SHALL set, and out_data SHALL keep the old word.
REQ-022 If the handshake and the transfer happen in the same cycle, the new word SHALL load with no overflow.
REQ-023 out_valid SHALL clear on handshake unless a new word loads in the same cycle.
REQ-024 clr_err SHALL clear ovf and dbl. A set event in the same cycle SHALL win.

Reset
REQ-025 rst SHALL asynchronously force: synchronizers 0, state IDLE, pending 0, count 0, assembly 0, out_data 0, out_valid 0, ovf 0, dbl 0, prime pending.
REQ-026 rst asserted mid-word SHALL discard the partial word. After release, the block SHALL require a prime cycle plus one s_p before committing bits.

Configuration
REQ-027 Macro SFQ_OUT_DESER_PULSE_CNT_EN: when defined, add output pulse_cnt (16 bits) counting every d_p outside the prime cycle, including d_p in IDLE. It SHALL wrap at 0xFFFF to 0, reset to 0 and clear on clr_err. When undefined, the port and counter SHALL be absent and all other behaviour is identical.

Structure
REQ-028 Shared package sfq_if_pkg SHALL hold the window-state enum (IDLE, OPEN), the default WIDTH and SYNC_STAGES constants, and the pulse_cnt width constant.
REQ-029 Sub-module sfq_toggle_det (synchronizer, prime handling, edge detect) SHALL be instantiated twice, once for din_t and once for slot_t.

Verification
REQ-030 WIDTH=4: prime, one slot_t toggle, then slots with data pulses in the pattern 1,0,1,1, out_ready=1 -> out_data=4'b1101, out_valid high for 1 cycle.
REQ-031 d_p and s_p in the same cycle on slot 0 of a word, no other data -> out_data=4'b0001.
REQ-032 Two din_t toggles in one window -> bit=1, dbl=1; clr_err pulse -> dbl=0.
REQ-033 out_ready=0, 8 slots with all data pulses -> first word 4'b1111 held, ovf=1, out_valid stays 1; handshake -> out_valid=0.
REQ-034 rst after 2 of 4 slots; release with din_t=1 and slot_t=1 held -> no spurious pulses; next word assembled from fresh slots only.
REQ-035 With SFQ_OUT_DESER_PULSE_CNT_EN, 65537 din pulses -> pulse_cnt=1.
